// File: rtl/nlfsr_gen.sv
// rtl/nlfsr_gen.sv - weight-threshold NLFSR with serial seeding, entropy warm-up and free run
// An all-zero register on any INIT/RUN step reloads LOCK_SEED instead of shifting.
module nlfsr_gen #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAP_MASK   = 16'h1390,
  parameter int               WEIGHT     = 1,
  parameter int               INIT_STEPS = 32,
  parameter bit               MIX_RUN    = 1'b0,
  parameter logic [WIDTH-1:0] LOCK_SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_d,
  input  logic             seed_valid,
  input  logic             ent_i,
  input  logic             ent_ce,
  input  logic             run_ce,
  output logic             bit_o,
  output logic             bit_valid,
  output logic [WIDTH-1:0] state_o,
  output logic             busy,
  output logic             lockup,
  output logic [7:0]       lock_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_INIT = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int LW = $clog2(WIDTH + 1);
  localparam int SW = (INIT_STEPS < 2) ? 1 : $clog2(INIT_STEPS + 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(WIDTH - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(INIT_STEPS - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_b;
  logic [LW-1:0]    r_load_cnt;
  logic [SW-1:0]    r_step_cnt;
  logic             r_bit_o;
  logic             r_bit_valid;
  logic             r_busy;
  logic             r_lockup;
  logic [7:0]       r_lock_cnt;

  logic [LW-1:0]    w_pop;
  logic             w_f;
  logic             w_zero;
  logic             w_mix;
  logic             w_in;
  logic             w_run_step;
  logic             w_step;
  logic [WIDTH-1:0] w_step_b;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pop = w_pop + LW'(r_b[i] & TAP_MASK[i]);
  end

  assign w_f        = (int'(w_pop) == WEIGHT);
  assign w_zero     = (r_b == '0);
  // start in RUN takes precedence over run_ce, so the abort never emits a bit
  assign w_run_step = (r_state == S_RUN) && !start && run_ce;
  assign w_step     = w_run_step || ((r_state == S_INIT) && ent_ce);
  assign w_mix      = (r_state == S_INIT) ? ent_i : (MIX_RUN & ent_ce & ent_i);
  assign w_in       = r_b[0] ^ w_f ^ w_mix;
  assign w_step_b   = w_zero ? LOCK_SEED : {w_in, r_b[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_b         <= '0;
      r_load_cnt  <= '0;
      r_step_cnt  <= '0;
      r_bit_o     <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_lockup    <= 1'b0;
      r_lock_cnt  <= 8'd0;
    end else begin
      r_bit_valid <= 1'b0;
      r_lockup    <= 1'b0;
      if (w_step) begin
        r_b <= w_step_b;
        if (w_zero) begin
          r_lockup <= 1'b1;
          if (r_lock_cnt != 8'hFF)
            r_lock_cnt <= r_lock_cnt + 8'd1;
        end
      end
      if (w_run_step) begin
        r_bit_o     <= r_b[0];
        r_bit_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_load_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (seed_valid) begin
            r_b        <= {seed_d, r_b[WIDTH-1:1]};
            r_load_cnt <= r_load_cnt + LW'(1);
            if (r_load_cnt == LOAD_LAST) begin
              r_step_cnt <= '0;
              if (INIT_STEPS == 0) begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_INIT;
              end
            end
          end
        end
        S_INIT: begin
          if (ent_ce) begin
            r_step_cnt <= r_step_cnt + SW'(1);
            if (r_step_cnt == STEP_LAST) begin
              r_state <= S_RUN;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_load_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign bit_o     = r_bit_o;
  assign bit_valid = r_bit_valid;
  assign state_o   = r_b;
  assign busy      = r_busy;
  assign lockup    = r_lockup;
  assign lock_cnt  = r_lock_cnt;

endmodule

// File: tb/tb_nlfsr_gen.sv
// tb/tb_nlfsr_gen.sv - scoreboard bench for nlfsr_gen: three instances with different parameters
// Expected RUN outputs are queued at stimulus time and popped by a negedge monitor.
module tb_nlfsr_gen;

  typedef struct {
    logic        bo;
    logic [15:0] st;
    logic        lk;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_d, seed_valid, ent_i, ent_ce;
  logic        start_a, start_b, start_c;
  logic        run_a, run_b, run_c;
  logic        a_bo, a_bv, a_busy, a_lk;
  logic        b_bo, b_bv, b_busy, b_lk;
  logic        c_bo, c_bv, c_busy, c_lk;
  logic [15:0] a_st, b_st;
  logic [7:0]  c_st;
  logic [7:0]  a_cnt, b_cnt, c_cnt;

  exp_t        q_a[$], q_b[$], q_c[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m;

  always #5 clk = ~clk;

  nlfsr_gen #(.INIT_STEPS(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .seed_d(seed_d), .seed_valid(seed_valid),
    .ent_i(ent_i), .ent_ce(ent_ce), .run_ce(run_a), .bit_o(a_bo), .bit_valid(a_bv),
    .state_o(a_st), .busy(a_busy), .lockup(a_lk), .lock_cnt(a_cnt));

  nlfsr_gen #(.INIT_STEPS(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .seed_d(seed_d), .seed_valid(seed_valid),
    .ent_i(ent_i), .ent_ce(ent_ce), .run_ce(run_b), .bit_o(b_bo), .bit_valid(b_bv),
    .state_o(b_st), .busy(b_busy), .lockup(b_lk), .lock_cnt(b_cnt));

  nlfsr_gen #(.WIDTH(8), .TAP_MASK(8'h16), .WEIGHT(2), .INIT_STEPS(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .seed_d(seed_d), .seed_valid(seed_valid),
    .ent_i(ent_i), .ent_ce(ent_ce), .run_ce(run_c), .bit_o(c_bo), .bit_valid(c_bv),
    .state_o(c_st), .busy(c_busy), .lockup(c_lk), .lock_cnt(c_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] st_of(input int id);
    case (id)
      0:       return a_st;
      1:       return b_st;
      default: return {8'h00, c_st};
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic cmp_out(input string tag, input logic bo, input logic [15:0] s,
                         input logic lk, input logic [7:0] cnt, input exp_t e);
    chk({tag, ".bit_o"}, 32'(bo), 32'(e.bo));
    chk({tag, ".state_o"}, 32'(s), 32'(e.st));
    chk({tag, ".lockup"}, 32'(lk), 32'(e.lk));
    chk({tag, ".lock_cnt"}, 32'(cnt), 32'(e.cnt));
  endtask

  task automatic unexpected(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s.bit_valid: got 1 expected 0 (no step issued)", tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_bv === 1'b1) begin
      if (q_a.size() == 0) unexpected("dut0");
      else begin e = q_a.pop_front(); cmp_out("dut0", a_bo, a_st, a_lk, a_cnt, e); end
    end
    if (b_bv === 1'b1) begin
      if (q_b.size() == 0) unexpected("dut1");
      else begin e = q_b.pop_front(); cmp_out("dut1", b_bo, b_st, b_lk, b_cnt, e); end
    end
    if (c_bv === 1'b1) begin
      if (q_c.size() == 0) unexpected("dut2");
      else begin e = q_c.pop_front(); cmp_out("dut2", c_bo, {8'h00, c_st}, c_lk, c_cnt, e); end
    end
  end

  task automatic pulse_start(input int id, input logic [15:0] held);
    set_start(id, 1'b1);
    tick();
    set_start(id, 1'b0);
    chk($sformatf("dut%0d.busy_after_start", id), 32'(busy_of(id)), 32'd1);
    chk($sformatf("dut%0d.held_after_start", id), 32'(st_of(id)), 32'(held));
  endtask

  // Serial seed, LSB first; model tracks the partially shifted register
  task automatic load_bits(input int id, input logic [15:0] val, input int n,
                           input bit stall, inout logic [15:0] mm);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        seed_valid = 1'b0;
        seed_d     = ~val[i];
        tick();
        chk($sformatf("dut%0d.stall_hold_%0d", id, i), 32'(st_of(id)), 32'(mm));
      end
      seed_valid = 1'b1;
      seed_d     = val[i];
      tick();
      mm = (mm >> 1) | (16'(val[i]) << (n - 1));
    end
    seed_valid = 1'b0;
    seed_d     = 1'b0;
    chk($sformatf("dut%0d.loaded", id), 32'(st_of(id)), 32'(mm));
  endtask

  logic [15:0] init_st[4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001};
  logic        init_lk[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        init_bz[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b0;
    {seed_d, seed_valid, ent_i, ent_ce} = 4'b0;
    {start_a, start_b, start_c, run_a, run_b, run_c} = 6'b0;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      seed_d = 1'($urandom); seed_valid = 1'($urandom);
      ent_i = 1'($urandom); ent_ce = 1'($urandom);
      start_a = 1'($urandom); start_b = 1'($urandom); start_c = 1'($urandom);
      run_a = 1'($urandom); run_b = 1'($urandom); run_c = 1'($urandom);
      tick();
    end
    {seed_d, seed_valid, ent_i, ent_ce} = 4'b0;
    {start_a, start_b, start_c, run_a, run_b, run_c} = 6'b0;
    chk("rst.state_o", 32'(a_st), 32'd0);
    chk("rst.bit_valid", 32'(a_bv), 32'd0);
    chk("rst.busy", 32'(a_busy), 32'd0);
    chk("rst.lock_cnt", 32'(a_cnt), 32'd0);
    chk("rst.lockup", 32'(a_lk), 32'd0);
    chk("rst.bit_o", 32'(a_bo), 32'd0);
    chk("rst.state_o_b", 32'(b_st), 32'd0);
    chk("rst.state_o_c", 32'(c_st), 32'd0);
    rst = 1'b1;
    tick();

    // load 0001 with stalls, then five back-to-back run steps
    m = 16'h0000;
    pulse_start(0, m);
    load_bits(0, 16'h0001, 16, 1'b1, m);
    chk("dut0.busy_after_load", 32'(a_busy), 32'd0);
    q_a.push_back('{1'b1, 16'h8000, 1'b0, 8'd0});
    q_a.push_back('{1'b0, 16'h4000, 1'b0, 8'd0});
    q_a.push_back('{1'b0, 16'h2000, 1'b0, 8'd0});
    q_a.push_back('{1'b0, 16'h1000, 1'b0, 8'd0});
    q_a.push_back('{1'b0, 16'h8800, 1'b0, 8'd0});
    run_a = 1'b1;
    repeat (5) tick();
    run_a = 1'b0;
    tick();

    // lockup in RUN: abort, load zero seed, one step
    m = 16'h8800;
    pulse_start(0, m);
    load_bits(0, 16'h0000, 16, 1'b0, m);
    chk("dut0.busy_after_zero_load", 32'(a_busy), 32'd0);
    q_a.push_back('{1'b0, 16'h0001, 1'b1, 8'd1});
    run_a = 1'b1;
    tick();
    run_a = 1'b0;
    tick();
    chk("dut0.lock_cnt_after", 32'(a_cnt), 32'd1);
    chk("dut0.lockup_cleared", 32'(a_lk), 32'd0);

    // warm-up with entropy, start ignored in INIT, one ent_ce stall
    m = 16'h0000;
    pulse_start(1, m);
    load_bits(1, 16'h0001, 16, 1'b0, m);
    chk("dut1.busy_in_init", 32'(b_busy), 32'd1);
    ent_i = 1'b1;
    ent_ce = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk($sformatf("dut1.init_state_%0d", k), 32'(b_st), 32'(init_st[k]));
      chk($sformatf("dut1.init_lockup_%0d", k), 32'(b_lk), 32'(init_lk[k]));
      chk($sformatf("dut1.init_busy_%0d", k), 32'(b_busy), 32'(init_bz[k]));
      if (k == 2) begin
        ent_ce = 1'b0;
        tick();
        chk("dut1.init_stall_state", 32'(b_st), 32'h0000);
        chk("dut1.init_stall_lockup", 32'(b_lk), 32'd0);
        ent_ce = 1'b1;
      end
    end
    ent_ce = 1'b0;
    ent_i = 1'b0;
    chk("dut1.lock_cnt_init", 32'(b_cnt), 32'd2);

    // start with run_ce in RUN: start wins, register held until seed bits arrive
    start_b = 1'b1;
    run_b = 1'b1;
    tick();
    start_b = 1'b0;
    run_b = 1'b0;
    chk("dut1.abort_busy", 32'(b_busy), 32'd1);
    chk("dut1.abort_state", 32'(b_st), 32'h0001);
    m = 16'h0001;
    load_bits(1, 16'hA5C3, 16, 1'b1, m);
    chk("dut1.busy_reload", 32'(b_busy), 32'd1);

    // WIDTH=8 instance
    m = 16'h0000;
    pulse_start(2, m);
    load_bits(2, 16'h0006, 8, 1'b1, m);
    chk("dut2.busy_after_load", 32'(c_busy), 32'd0);
    q_c.push_back('{1'b0, 16'h0083, 1'b0, 8'd0});
    run_c = 1'b1;
    tick();
    run_c = 1'b0;
    tick();
    tick();

    chk("dut0.queue_drained", 32'(q_a.size()), 32'd0);
    chk("dut1.queue_drained", 32'(q_b.size()), 32'd0);
    chk("dut2.queue_drained", 32'(q_c.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nlfsr_gen.md
# nlfsr_gen

Parametrised nonlinear feedback shift register for the TRNG entropy path, generalising the fixed 16-bit NLFSR stages. It adds configurable width, tap mask and weight-threshold feedback, plus a control FSM that sequences serial seeding, an entropy-mixing warm-up and free running. It also detects the all-zero lockup state and recovers from it. It sits between the warbler and ring-oscillator entropy sources and the downstream stages that consume its output bit stream.

## Interface
- WIDTH, 16: register length; legal range is 4 or more.
- TAP_MASK, 16'h1390: bit i set selects b[i] as a nonlinear-function input.
- WEIGHT, 1: f = 1 iff popcount(b & TAP_MASK) == WEIGHT.
- INIT_STEPS, 32: number of warm-up steps; 0 is legal and means no warm-up.
- MIX_RUN, 0: when 1, entropy is also XORed into feedback in RUN.
- LOCK_SEED, {{WIDTH-1{0}},1}: value written when lockup is detected; must be nonzero.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a seeding sequence.
- seed_d  in  1  serial seed bit.
- seed_valid  in  1  seed_d is valid this cycle.
- ent_i  in  1  entropy bit (warbler output).
- ent_ce  in  1  entropy-step enable.
- run_ce  in  1  step enable in RUN.
- bit_o  out  1  bit shifted out (old b[0]).
- bit_valid  out  1  bit_o valid; one-cycle pulse.
- state_o  out  WIDTH  current register b.
- busy  out  1  high in LOAD or INIT.
- lockup  out  1  one-cycle pulse on each lockup reseed.
- lock_cnt  out  8  saturating count of lockup events.

## Operation
- FSM states are IDLE, LOAD, INIT and RUN. Reset (rst=0 at a clock edge) forces:
  - IDLE, b=0, load counter and step counter = 0;
  - all outputs 0.
- Feedback terms:
  - f = (popcount(b & TAP_MASK) == WEIGHT);
  - fb = b[0] ^ f.
- Shift form for every step: b_next = {in, b[WIDTH-1:1]}.
- IDLE: b holds. start=1 moves to LOAD and clears the load counter.
- LOAD:
  - Each cycle with seed_valid=1: in = seed_d, and the load counter increments.
  - The first accepted bit ends up in b[0] after WIDTH accepted bits.
  - Cycles with seed_valid=0 stall (b holds).
  - After the WIDTH-th accepted bit: go to INIT, or to RUN if INIT_STEPS=0.
  - The step counter is cleared on this transition.
- INIT:
  - A step occurs only on cycles with ent_ce=1, with in = fb ^ ent_i.
  - The step counter increments on each step.
  - After the INIT_STEPS-th step, go to RUN.
  - ent_ce=0 stalls (b holds).
- RUN:
  - A step occurs on cycles with run_ce=1.
  - in = fb ^ (MIX_RUN & ent_ce & ent_i).
- Lockup, in INIT or RUN:
  - If a step is due and b == 0, then b_next = LOCK_SEED instead of the shift.
  - lockup pulses for that step; lock_cnt increments, saturating at 255.
  - The step still counts as a step (INIT counter advances; bit_valid pulses in RUN with bit_o=0).
  - LOAD never checks for lockup.
- Output bits: every RUN step registers bit_o = pre-step b[0] and pulses bit_valid. INIT steps do not produce bit_valid.
- start handling:
  - start in RUN aborts to LOAD; b holds until the first accepted seed bit.
  - start in LOAD or INIT is ignored.
  - lock_cnt is cleared only by reset.

## Timing
- Every state transition takes effect at the clock edge where its condition is sampled.
- busy is a registered decode of the state: it is high in the cycle after start is sampled in IDLE.
- Seeding latency: minimum WIDTH cycles in LOAD plus INIT_STEPS cycles in INIT, when seed_valid and ent_ce are held high.
- bit_o, bit_valid and lockup change in the cycle after the step edge, together with state_o.
- bit_valid is low in every cycle without a RUN step.
- Back-to-back run_ce gives one bit per cycle.
- Simultaneous start and run_ce in RUN: start wins; no step, no bit_valid.
- Reset mid-LOAD or mid-INIT takes effect at the next edge and returns the block to the full reset state.

## Test plan
Tests 1–5 use default parameters unless stated otherwise.
1. Reset: drive rst=0 for 2 cycles with random inputs -> state_o=0, bit_valid=0, busy=0, lock_cnt=0, lockup=0.
2. Load and run, INIT_STEPS=0:
   - Load seed 16'h0001 (1 then fifteen 0s) with seed_valid toggling 50%; stall cycles must not advance.
   - Then run_ce=1 -> state sequence 8000, 4000, 2000, 1000, 8800.
   - bit_o sequence 1, 0, 0, 0, 0, with a bit_valid pulse on each.
3. Lockup in RUN, INIT_STEPS=0: load seed 0, then run_ce=1 -> state_o=16'h0001 after the first step, lockup pulse, lock_cnt=1, bit_o=0.
4. Entropy warm-up, INIT_STEPS=4:
   - Load seed 1, then hold ent_ce=1 and ent_i=1.
   - State sequence 0000, 0001 (lockup), 0000, 0001 (lockup), giving lock_cnt=2.
   - Block enters RUN after the 4th step; busy falls; no bit_valid during INIT.
5. Abort and precedence:
   - start during INIT -> ignored.
   - start together with run_ce in RUN -> no step and no bit_valid; busy=1 next cycle; state_o held until seed bits arrive.
6. Generality: WIDTH=8, TAP_MASK=8'h16, WEIGHT=2, seed 8'h06, INIT_STEPS=0, one run_ce step -> state_o=8'h83, bit_o=0, no lockup pulse.
